// File: rtl/countdown_sched_pkg.sv
// countdown_sched shared types and defaults.
// State encodings and default sizing for the shared countdown scheduler.
package countdown_sched_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_sched_rr_arbiter.sv
// Combinational picker for countdown_sched: round-robin from ptr+1,
// or lowest-index-wins when COUNTDOWN_SCHED_PRIO_EN is defined.
module rr_arbiter
  import countdown_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   idx
);

`ifdef COUNTDOWN_SCHED_PRIO_EN
  always_comb begin : prio
    logic found;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        pick[i] = 1'b1;
        idx     = IW'(i);
      end
    end
  end
`else
  always_comb begin : rr
    logic found;
    int   j;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        pick[j] = 1'b1;
        idx     = IW'(j);
      end
    end
  end
`endif

endmodule

// File: rtl/countdown_sched.sv
// Shared WIDTH-bit down counter time-multiplexed among NREQ requesters.
// Optional fixed-priority arbitration via COUNTDOWN_SCHED_PRIO_EN.
module countdown_sched
  import countdown_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] load_val,
  input  logic                  pause,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic [NREQ-1:0]       done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    win_q, win_d;
  logic [NREQ-1:0]  pick;
  logic [IW-1:0]    pick_idx;
  logic             abort;
  logic             at_zero;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx)
  );

  assign abort   = !req[win_q];
  assign at_zero = (count_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      count_q <= '0;
      ptr_q   <= IW'(NREQ - 1);
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (|req) state_d = S_COUNT;
      S_COUNT: begin
        if (abort)                 state_d = S_IDLE;
        else if (!pause && at_zero) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Abort wins over pause and expiry; ptr advances only when service ends.
  always_comb begin
    grant_d = grant_q;
    count_d = count_q;
    done_d  = '0;
    ptr_d   = ptr_q;
    win_d   = win_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d = pick;
          count_d = load_val[int'(pick_idx)*WIDTH +: WIDTH];
          win_d   = pick_idx;
        end
      end
      S_COUNT: begin
        if (abort) begin
          grant_d = '0;
          count_d = '0;
          ptr_d   = win_q;
        end else if (!pause) begin
          if (!at_zero) count_d = count_q - WIDTH'(1);
          else          done_d  = grant_q;
        end
      end
      S_DONE: begin
        grant_d = '0;
        ptr_d   = win_q;
      end
      default: begin
        grant_d = '0;
        count_d = '0;
      end
    endcase
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign count = count_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_countdown_sched.sv
// Directed bench for countdown_sched with hand-computed expectations.
// Arbitration checks follow COUNTDOWN_SCHED_PRIO_EN when defined.
module tb_countdown_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] load_val = '0;
  logic                  pause = 1'b0;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic [NREQ-1:0]       done;

  int total = 0;
  int bad   = 0;

  countdown_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .load_val (load_val),
    .pause    (pause),
    .grant    (grant),
    .busy     (busy),
    .count    (count),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".grant"}, 32'(grant), 32'h0);
    chk({tag, ".busy"},  32'(busy),  32'h0);
    chk({tag, ".count"}, 32'(count), 32'h0);
    chk({tag, ".done"},  32'(done),  32'h0);
  endtask

  initial begin
    logic [NREQ-1:0] exp_g;

    // 1: reset values, basic L=3 service
    do_reset();
    chk_idle("rst");
    req      = 4'b0001;
    load_val = 16'h0003;
    tick();
    chk("t1.grant", 32'(grant), 32'h1);
    chk("t1.busy",  32'(busy),  32'h1);
    chk("t1.c3",    32'(count), 32'h3);
    tick(); chk("t1.c2", 32'(count), 32'h2);
    tick(); chk("t1.c1", 32'(count), 32'h1);
    tick(); chk("t1.c0", 32'(count), 32'h0);
    chk("t1.nodone", 32'(done), 32'h0);
    tick();
    chk("t1.done",  32'(done),  32'h1);
    chk("t1.gdone", 32'(grant), 32'h1);
    chk("t1.bdone", 32'(busy),  32'h1);
    req = '0;
    tick();
    chk_idle("t1.end");

    // 2: all requesting, L=1 each
    do_reset();
    req      = 4'b1111;
    load_val = 16'h1111;
    for (int s = 0; s < 5; s++) begin
`ifdef COUNTDOWN_SCHED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (s % 4);
`endif
      tick();
      chk("t2.grant", 32'(grant), 32'(exp_g));
      chk("t2.c1",    32'(count), 32'h1);
      tick();
      chk("t2.c0",    32'(count), 32'h0);
      chk("t2.nodone", 32'(done), 32'h0);
      tick();
      chk("t2.done",  32'(done),  32'(exp_g));
      if (s == 4) req = '0;
      tick();
      chk("t2.gap",   32'(grant), 32'h0);
      chk("t2.gapb",  32'(busy),  32'h0);
    end

`ifdef COUNTDOWN_SCHED_PRIO_EN
    req = 4'b1110;
    tick();
    chk("t6.grant", 32'(grant), 32'h2);
    req = '0;
    tick();
    tick();
    tick();
`endif

    // 3: pause holds count for 3 cycles
    req      = 4'b0100;
    load_val = 16'h0200;
    tick();
    chk("t3.grant", 32'(grant), 32'h4);
    chk("t3.c2",    32'(count), 32'h2);
    pause = 1'b1;
    for (int p = 0; p < 3; p++) begin
      tick();
      chk("t3.hold",  32'(count), 32'h2);
      chk("t3.nodn",  32'(done),  32'h0);
    end
    pause = 1'b0;
    tick(); chk("t3.c1", 32'(count), 32'h1);
    tick(); chk("t3.c0", 32'(count), 32'h0);
    chk("t3.nodone", 32'(done), 32'h0);
    tick(); chk("t3.done", 32'(done), 32'h4);
    req = '0;
    tick();
    chk_idle("t3.end");

    // 4: zero load value, then with pause at expiry edge
    req      = 4'b0010;
    load_val = 16'h0000;
    tick();
    chk("t4.grant", 32'(grant), 32'h2);
    chk("t4.c0",    32'(count), 32'h0);
    tick();
    chk("t4.done",  32'(done),  32'h2);
    req = '0;
    tick();
    chk_idle("t4.idle");
    req = 4'b0010;
    tick();
    chk("t4.grant2", 32'(grant), 32'h2);
    pause = 1'b1;
    tick(); chk("t4.p1", 32'(done), 32'h0);
    tick(); chk("t4.p2", 32'(done), 32'h0);
    chk("t4.pbusy", 32'(busy), 32'h1);
    pause = 1'b0;
    tick(); chk("t4.done2", 32'(done), 32'h2);
    req = '0;
    tick();

    // 5: abort, then async reset mid-count
    req      = 4'b0001;
    load_val = 16'h0005;
    tick(); chk("t5.c5", 32'(count), 32'h5);
    tick(); chk("t5.c4", 32'(count), 32'h4);
    tick(); chk("t5.c3", 32'(count), 32'h3);
    tick(); chk("t5.c2", 32'(count), 32'h2);
    req = '0;
    tick();
    chk_idle("t5.abort");
    tick();
    chk("t5.stay", 32'(done), 32'h0);
    req = 4'b0001;
    tick(); chk("t5.g", 32'(grant), 32'h1);
    tick(); chk("t5.c4b", 32'(count), 32'h4);
    #2;
    rst = 1'b0;
    #1;
    chk_idle("t5.arst");
    tick();
    rst = 1'b1;
    req = '0;
    tick();
    chk_idle("t5.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
